mux_rr_scheduler: RTL

Round-robin scheduler that shares the team's 4:1 gate-level mux between four single-bit requesters. It chooses which requester owns the mux and drives the mux select. It returns a one-hot grant to the requesters. It presents the selected bit downstream on a valid/ready handshake, with a bounded burst length per grant.

---
 rtl/mux_sched_pkg.sv | 19 +
 rtl/mux_4to1.sv | 25 ++
 rtl/rr_pick.sv | 39 +++
 rtl/mux_rr_scheduler.sv | 104 ++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types, sizes and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Gate-level 4:1 mux: y = d[s]. Built from primitives so it maps one-to-one onto cells.
module mux_4to1 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);

    wire s0_n;
    wire s1_n;
    wire t0;
    wire t1;
    wire t2;
    wire t3;

    not n0 (s0_n, s[0]);
    not n1 (s1_n, s[1]);

    and g0 (t0, d[0], s0_n, s1_n);
    and g1 (t1, d[1], s[0], s1_n);
    and g2 (t2, d[2], s0_n, s[1]);
    and g3 (t3, d[3], s[0], s[1]);

    assign y = t0 | t1 | t2 | t3;

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority encoder: searches last_ptr+1 .. last_ptr+4 (mod 4), so the
// previous owner is always considered last.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic             any,
    output logic [SEL_W-1:0] pick
);

    logic [SEL_W-1:0] cand1;
    logic [SEL_W-1:0] cand2;
    logic [SEL_W-1:0] cand3;
    logic [SEL_W-1:0] cand4;

    // Two-bit adds wrap naturally, giving the mod-4 search order.
    assign cand1 = last_ptr + 2'd1;
    assign cand2 = last_ptr + 2'd2;
    assign cand3 = last_ptr + 2'd3;
    assign cand4 = last_ptr;

    always_comb begin
        any  = 1'b1;
        pick = last_ptr;
        if (req[cand1]) begin
            pick = cand1;
        end else if (req[cand2]) begin
            pick = cand2;
        end else if (req[cand3]) begin
            pick = cand3;
        end else if (req[cand4]) begin
            pick = cand4;
        end else begin
            any = 1'b0;
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner selection for the shared 4:1 mux, with a bounded burst per
// grant and a valid/ready downstream port.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] x,
    output logic [SEL_W-1:0] a,
    output logic [N_REQ-1:0] grant,
    output logic             out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // Handshake: a beat moves when out_valid && out_ready on a rising edge.
    // out_valid is the owner's live request, so an owner dropping req withdraws
    // valid in the same cycle and that cycle never counts as a transfer.

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic [SEL_W-1:0] last_ptr;
    logic             any;
    logic [SEL_W-1:0] pick;
    logic             transfer;
    logic             last_beat;
    logic             exit_evt;

    rr_pick u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .any      (any),
        .pick     (pick)
    );

    mux_4to1 u_mux (
        .d (x),
        .s (a),
        .y (out_data)
    );

    assign busy      = (state == GRANT);
    assign out_valid = busy && req[a];
    assign transfer  = out_valid && out_ready;
    assign last_beat = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign exit_evt  = busy && ((transfer && last_beat) || !req[a]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            grant     <= '0;
            burst_cnt <= '0;
            last_ptr  <= SEL_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        a         <= pick;
                        grant     <= onehot(pick);
                        last_ptr  <= pick;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (exit_evt) begin
                        burst_cnt <= '0;
                        if (any) begin
                            // Hand over without an idle bubble; may re-grant the same owner.
                            a        <= pick;
                            grant    <= onehot(pick);
                            last_ptr <= pick;
                        end else begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end else if (transfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    a_grant_iff_state : assert property (@(posedge clk) disable iff (!rst_n)
        (grant != '0) == (state == GRANT));

    a_grant_matches_sel : assert property (@(posedge clk) disable iff (!rst_n)
        (state == GRANT) |-> (grant == onehot(a)));

endmodule
